// File: rtl/dac_sample_feeder.sv
// Sample-rate front end for the audio sigma-delta DAC: buffers signed samples in a
// small FIFO and releases one offset-binary code every SAMPLE_PERIOD cycles.
module dac_sample_feeder #(
    parameter int CODE_WIDTH    = 10,
    parameter int SAMPLE_PERIOD = 2834,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CODE_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CODE_WIDTH-1:0]         code,
    output logic                          sample_tick,
    output logic                          underflow,
    output logic [7:0]                    underflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PTR_W:0]        FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CODE_WIDTH-1:0] MIDSCALE = {1'b1, {(CODE_WIDTH - 1){1'b0}}};

    logic [CODE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_fill;
    logic [CNT_W-1:0]      r_cnt;
    logic [CODE_WIDTH-1:0] r_code;
    logic                  r_tick;
    logic                  r_underflow;
    logic [7:0]            r_ucount;

    logic w_tick;
    logic w_empty;
    logic w_in_ready;
    logic w_push;
    logic w_pop;

    // Handshake: a word transfers on every posedge where in_valid && in_ready; in_ready
    // depends only on rst and registered occupancy, never on in_valid.
    assign w_in_ready = !rst && (r_fill != FILL_FULL);
    assign w_tick     = (r_cnt == CNT_LAST);
    // Emptiness uses registered fill, so a word pushed in the tick cycle waits a period.
    assign w_empty    = (r_fill == '0);
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = w_tick && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_code      <= MIDSCALE;
            r_tick      <= 1'b0;
            r_underflow <= 1'b0;
            r_ucount    <= '0;
        end else begin
            r_cnt       <= w_tick ? '0 : r_cnt + 1'b1;
            r_tick      <= w_tick;
            r_underflow <= w_tick && w_empty;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_code   <= r_mem[r_rd_ptr] ^ MIDSCALE;
            end
            if (w_tick && w_empty && (r_ucount != 8'hFF)) begin
                r_ucount <= r_ucount + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign in_ready        = w_in_ready;
    assign code            = r_code;
    assign sample_tick     = r_tick;
    assign underflow       = r_underflow;
    assign underflow_count = r_ucount;
    assign fill            = r_fill;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder (CODE_WIDTH=10, SAMPLE_PERIOD=4, FIFO_DEPTH=4)
// with a queue-based reference model checked every cycle plus hand-computed checkpoints.
module tb_dac_sample_feeder;

    logic       clk;
    logic       rst;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] code;
    logic       sample_tick;
    logic       underflow;
    logic [7:0] underflow_count;
    logic [2:0] fill;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [9:0] exp_q[$];
    logic [9:0] m_code = 10'd512;
    logic       m_tick = 1'b0;
    logic       m_uf = 1'b0;
    logic [7:0] m_ucnt = 8'd0;
    int         m_cnt = 0;

    dac_sample_feeder #(
        .CODE_WIDTH(10),
        .SAMPLE_PERIOD(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .code(code),
        .sample_tick(sample_tick),
        .underflow(underflow),
        .underflow_count(underflow_count),
        .fill(fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance one clock, update the model, drive inputs for the new cycle, compare at negedge.
    task automatic cyc_step(input logic v, input logic [9:0] d, input logic r);
        logic       was_rst;
        logic       push;
        logic       tick;
        logic       pop;
        logic [9:0] din;
        was_rst = rst;
        push    = in_valid && !rst && (exp_q.size() != 4);
        tick    = !rst && (m_cnt == 3);
        pop     = tick && (exp_q.size() != 0);
        din     = in_data;
        @(posedge clk);
        if (was_rst) begin
            exp_q.delete();
            m_cnt  = 0;
            m_code = 10'd512;
            m_tick = 1'b0;
            m_uf   = 1'b0;
            m_ucnt = 8'd0;
            cyc    = 0;
        end else begin
            cyc++;
            m_tick = tick;
            m_uf   = 1'b0;
            if (pop) begin
                m_code = exp_q.pop_front();
            end else if (tick) begin
                m_uf = 1'b1;
                if (m_ucnt != 8'hFF) m_ucnt = m_ucnt + 8'd1;
            end
            if (push) exp_q.push_back(din ^ 10'h200);
            m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
        end
        #1;
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        check("code", 32'(code), 32'(m_code));
        check("sample_tick", 32'(sample_tick), 32'(m_tick));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("underflow_count", 32'(underflow_count), 32'(m_ucnt));
        check("fill", 32'(fill), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(!rst && (exp_q.size() != 4)));
    endtask

    task automatic do_reset();
        cyc_step(1'b0, 10'd0, 1'b1);
        cyc_step(1'b0, 10'd0, 1'b0);
    endtask

    initial begin
        int idx;
        int acc5;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 10'd0;
        idx      = 0;
        acc5     = -1;

        // Reset held three edges; release coincides with the first push of -512.
        for (int i = 0; i < 2; i++) begin
            cyc_step(1'b0, 10'd0, 1'b1);
            check("rst_code", 32'(code), 32'd512);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_fill", 32'(fill), 32'd0);
            check("rst_ucount", 32'(underflow_count), 32'd0);
        end
        cyc_step(1'b1, 10'h200, 1'b0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_code", 32'(code), 32'd512);
        check("rel_cyc0", 32'(cyc), 32'd0);

        // Conversion ordering: -512, 0, 511.
        cyc_step(1'b1, 10'h000, 1'b0);
        cyc_step(1'b1, 10'h1FF, 1'b0);
        for (int c = 3; c <= 14; c++) begin
            cyc_step(1'b0, 10'd0, 1'b0);
            if (cyc == 4)  check("conv_code0", 32'(code), 32'd0);
            if (cyc == 8)  check("conv_code1", 32'(code), 32'd512);
            if (cyc == 12) check("conv_code2", 32'(code), 32'd1023);
            if (cyc == 4 || cyc == 8 || cyc == 12) begin
                check("conv_tick", 32'(sample_tick), 32'd1);
                check("conv_no_uf", 32'(underflow), 32'd0);
            end
        end

        // Backpressure: six words 10..15 offered continuously from cycle 15.
        for (int c = 15; c <= 44; c++) begin
            cyc_step(idx < 6, 10'(10 + idx), 1'b0);
            if (in_valid && in_ready) begin
                if (idx == 4) acc5 = cyc;
                idx++;
            end
            if (cyc == 16) check("bp_uf_tick15", 32'(underflow), 32'd1);
            if (cyc == 19) begin
                check("bp_fill_full", 32'(fill), 32'd4);
                check("bp_ready_low", 32'(in_ready), 32'd0);
            end
            if (cyc >= 20 && cyc <= 40 && (cyc % 4) == 0)
                check("bp_code", 32'(code), 32'(522 + (cyc - 20) / 4));
            if (cyc == 44) begin
                check("bp_tail_uf", 32'(underflow), 32'd1);
                check("bp_tail_code", 32'(code), 32'd527);
            end
        end
        in_valid = 1'b0;
        check("bp_5th_accept_cycle", 32'(acc5), 32'd20);
        check("bp_all_accepted", 32'(idx), 32'd6);

        // Underflow saturation over 300 empty ticks, then one push of 100.
        do_reset();
        for (int c = 1; c <= 1200; c++) begin
            cyc_step(1'b0, 10'd0, 1'b0);
            if (cyc == 4)    check("uf_count1", 32'(underflow_count), 32'd1);
            if (cyc == 1016) check("uf_count254", 32'(underflow_count), 32'd254);
            if (cyc == 1020) check("uf_count255", 32'(underflow_count), 32'd255);
            if (cyc == 1200) begin
                check("uf_count_sat", 32'(underflow_count), 32'd255);
                check("uf_pulse", 32'(underflow), 32'd1);
                check("uf_code_held", 32'(code), 32'd512);
            end
        end
        cyc_step(1'b1, 10'd100, 1'b0);
        for (int c = 0; c < 3; c++) cyc_step(1'b0, 10'd0, 1'b0);
        check("uf_push_code", 32'(code), 32'd612);
        check("uf_push_no_uf", 32'(underflow), 32'd0);
        check("uf_push_count", 32'(underflow_count), 32'd255);

        // Push on the tick cycle with the FIFO empty.
        do_reset();
        cyc_step(1'b0, 10'd0, 1'b0);
        cyc_step(1'b0, 10'd0, 1'b0);
        cyc_step(1'b1, 10'd7, 1'b0);
        for (int c = 4; c <= 8; c++) begin
            cyc_step(1'b0, 10'd0, 1'b0);
            if (cyc == 4) begin
                check("pot_uf", 32'(underflow), 32'd1);
                check("pot_code_held", 32'(code), 32'd512);
                check("pot_fill", 32'(fill), 32'd1);
            end
            if (cyc == 8) begin
                check("pot_code", 32'(code), 32'd519);
                check("pot_no_uf", 32'(underflow), 32'd0);
            end
        end

        // Reset mid-stream with three words buffered and a handshake in the reset cycle.
        do_reset();
        cyc_step(1'b1, 10'd50, 1'b0);
        for (int c = 2; c <= 11; c++) cyc_step(1'b0, 10'd0, 1'b0);
        cyc_step(1'b1, 10'd1, 1'b0);
        check("ms_count_pre", 32'(underflow_count), 32'd2);
        check("ms_code_pre", 32'(code), 32'd562);
        cyc_step(1'b1, 10'd2, 1'b0);
        cyc_step(1'b1, 10'd3, 1'b0);
        cyc_step(1'b1, 10'd9, 1'b1);
        check("ms_fill_pre", 32'(fill), 32'd3);
        cyc_step(1'b0, 10'd0, 1'b0);
        check("ms_fill_post", 32'(fill), 32'd0);
        check("ms_code_post", 32'(code), 32'd512);
        check("ms_count_post", 32'(underflow_count), 32'd0);
        check("ms_ready_post", 32'(in_ready), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            cyc_step(1'b0, 10'd0, 1'b0);
            if (cyc == 4 || cyc == 8) begin
                check("ms_stale_uf", 32'(underflow), 32'd1);
                check("ms_stale_code", 32'(code), 32'd512);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Sample-rate front end for the audio sigma-delta DAC. Accepts signed two's-complement audio samples from the CPU/MMIO side over a ready/valid handshake and buffers them in a small FIFO. Releases one sample every SAMPLE_PERIOD clock cycles as an offset-binary `code` word that drives the DAC's `code` input directly. Holds the last code on underflow and counts underflow events.

## Interface
- `CODE_WIDTH`, 10: sample/code width in bits; must match the DAC.
- `SAMPLE_PERIOD`, 2834: clock cycles per output sample (≥2).
- `FIFO_DEPTH`, 8: sample buffer entries; power of two, ≥2.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  CODE_WIDTH  signed two's-complement sample.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept; transfer when `in_valid && in_ready`.
- `code`  out  CODE_WIDTH  offset-binary DAC code, registered.
- `sample_tick`  out  1  one-cycle pulse in the cycle `code` takes a new tick's value.
- `underflow`  out  1  one-cycle pulse, coincident with `sample_tick`, when the tick found the FIFO empty.
- `underflow_count`  out  8  saturating count of underflow ticks.
- `fill`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, registered.

## Operation
- Period counter `cnt` counts 0..SAMPLE_PERIOD-1 and wraps to 0. A tick occurs in every cycle where `cnt == SAMPLE_PERIOD-1`.
- On a tick with FIFO non-empty:
  - Pop the head.
  - `code <= head ^ (1 << (CODE_WIDTH-1))`, which inverts the MSB: -512→0, 0→512, 511→1023.
- On a tick with FIFO empty:
  - `code` is held.
  - `underflow` pulses.
  - `underflow_count` increments, saturating at 255 and never wrapping.
- FIFO behaviour:
  - Circular buffer with read/write pointers and an explicit occupancy count.
  - `in_ready = !rst && (fill != FIFO_DEPTH)`.
  - Push and pop in the same cycle leaves `fill` unchanged.
- Emptiness at a tick is judged on the registered `fill`. A word pushed in the tick cycle itself is not popped by that tick: the tick counts as an underflow and the word is stored.
- Full FIFO: `in_ready` is 0, so no push occurs even on a pop cycle. `in_ready` returns to 1 the cycle after the pop.
- Width rules: no arithmetic on sample data beyond the MSB inversion. `cnt` is $clog2(SAMPLE_PERIOD) bits wide.

## Timing
- Reset values, held while `rst`=1 and in the first cycle after release:
  - `code` = 1<<(CODE_WIDTH-1) (midscale, 512).
  - `sample_tick` = 0, `underflow` = 0, `underflow_count` = 0, `fill` = 0.
  - `cnt` = 0, FIFO pointers = 0.
  - `in_ready` = 0 during reset and 1 in the first cycle after release.
- Reset mid-operation discards all FIFO contents and returns every output to its reset value on the next edge. Any in-flight handshake in the reset cycle is dropped.
- Tick timing: `cnt` = 0 in the first cycle after reset release, so the first tick is cycle SAMPLE_PERIOD-1. Ticks repeat every SAMPLE_PERIOD cycles after that.
- A tick in cycle N produces `code`, `sample_tick` and `underflow` visible in cycle N+1. `code` is stable for SAMPLE_PERIOD cycles.
- Input latency: a word accepted in cycle P appears in `fill` in cycle P+1. It is eligible for the first tick at cycle ≥ P+1.
- `fill` updates one cycle after a push or pop.
- `underflow_count` updates in the same cycle as the `underflow` pulse.

## Test plan
All scenarios use CODE_WIDTH=10, SAMPLE_PERIOD=4, FIFO_DEPTH=4.
- Reset: hold `rst` 3 cycles.
  - During reset: `code`=512, `in_ready`=0, `fill`=0, `underflow_count`=0.
  - First cycle after release: `in_ready`=1.
- Conversion ordering: push -512, 0, 511 back-to-back immediately after reset.
  - Ticks produce `code` = 0, 512, 1023 in cycles 4, 8, 12.
  - `sample_tick` pulses in each of those cycles.
  - No `underflow`.
- Backpressure: hold `in_valid`=1 with incrementing data from a state where no pop occurs for 4 cycles.
  - `fill` reaches 4 and `in_ready` drops to 0.
  - The 5th word is accepted the cycle after the next tick's pop.
  - Output order is preserved with no duplicates or drops.
- Underflow and saturation: leave the FIFO empty for 300 ticks.
  - `code` holds its last value and `underflow` pulses on each tick.
  - `underflow_count` reads 255 from the 255th tick onward.
  - A subsequent push of 100 yields `code`=612 with no `underflow` on that tick.
- Push on tick cycle with the FIFO empty: push 7 in cycle 3.
  - Cycle 4: `underflow`=1 and `code` held at 512.
  - Cycle 8: `code`=519.
- Reset mid-stream: with `fill`=3, assert `rst` for 1 cycle.
  - Next cycle: `fill`=0, `code`=512, `underflow_count`=0.
  - No stale samples are emitted on subsequent ticks.
